// File: rtl/naneye_cfg_pkg.sv
// naneye_cfg_pkg: shared state encoding and parameter helpers for the NanEye config transmitter.
package naneye_cfg_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, OE, SHIFT, HOLD} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int half_cnt(input int clk_ps, input int bit_ns);
      return (bit_ns * 1000 + 2 * clk_ps - 1) / (2 * clk_ps);
   endfunction

   function automatic bit nwords_ok(input int nwords, input int bits, input int data_w);
      return nwords == (bits + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/naneye_cfg_rr_arb.sv
// naneye_cfg_rr_arb: round-robin pick of the first pending channel after last_ch.
module naneye_cfg_rr_arb
   import naneye_cfg_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0] pend,
   input  logic [CH_W-1:0] last_ch,
   output logic            grant,
   output logic [CH_W-1:0] grant_ch
);

   int idx;

   // Scan from lowest to highest priority so the nearest successor of last_ch wins.
   always_comb begin
      grant = |pend;
      grant_ch = '0;
      idx = 0;
      for (int i = N_CH; i >= 1; i--) begin
         idx = int'(last_ch) + i;
         idx = (idx >= N_CH) ? idx - N_CH : idx;
         if (pend[idx]) grant_ch = CH_W'(idx);
      end
   end

endmodule

// File: rtl/naneye_cfg_tx_multi.sv
// naneye_cfg_tx_multi: round-robin config transmitter serving N_CH NanEye sensors one at a time.
// Define NANEYE_CFG_PARITY_EN to append an even-parity bit after every payload.
module naneye_cfg_tx_multi
   import naneye_cfg_pkg::*;
#(
   parameter int CLOCK_PERIOD_PS = 20833,
   parameter int BIT_PERIOD_NS   = 400,
   parameter int C_NO_CFG_BITS   = 24,
   parameter int N_CH            = 4,
   parameter int DATA_W          = 16,
   parameter int NWORDS          = 2
) (
   input  logic                                 CLOCK,
   input  logic                                 RESET_N,
   input  logic [N_CH-1:0]                      START,
   input  logic [DATA_W-1:0]                    INPUT,
   output logic [clog2(N_CH)+clog2(NWORDS)-1:0] RD_ADDR,
   output logic                                 RD_EN,
   output logic [N_CH-1:0]                      TX_DAT,
   output logic [N_CH-1:0]                      TX_CLK,
   output logic [N_CH-1:0]                      TX_OE_N,
   output logic [N_CH-1:0]                      TX_END,
   output logic                                 BUSY
);

   localparam int CH_W   = clog2(N_CH);
   localparam int WORD_W = clog2(NWORDS);
   localparam int HALF   = half_cnt(CLOCK_PERIOD_PS, BIT_PERIOD_NS);
   localparam int SR_W   = NWORDS * DATA_W;
   localparam int CNT_W  = clog2(2 * HALF);
`ifdef NANEYE_CFG_PARITY_EN
   localparam int BITS   = C_NO_CFG_BITS + 1;
`else
   localparam int BITS   = C_NO_CFG_BITS;
`endif
   localparam int BC_W   = clog2(BITS);

   if (!nwords_ok(NWORDS, C_NO_CFG_BITS, DATA_W)) begin : g_bad_nwords
      $error("NWORDS must equal ceil(C_NO_CFG_BITS/DATA_W)");
   end

   state_t            state;
   logic [CH_W-1:0]   ch, last_ch, grant_ch;
   logic              grant, rd_q, nxt;
   logic [N_CH-1:0]   pend, sel, grant_oh;
   logic [WORD_W-1:0] widx;
   logic [SR_W-1:0]   sreg;
   logic [CNT_W-1:0]  cnt;
   logic [BC_W-1:0]   bcnt;

   naneye_cfg_rr_arb #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
      .pend     (pend),
      .last_ch  (last_ch),
      .grant    (grant),
      .grant_ch (grant_ch)
   );

   assign grant_oh = N_CH'(1) << grant_ch;

`ifdef NANEYE_CFG_PARITY_EN
   logic par;
   assign nxt = (bcnt == BC_W'(C_NO_CFG_BITS - 1)) ? par : sreg[SR_W-1];
`else
   assign nxt = sreg[SR_W-1];
`endif

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         pend    <= '0;
         last_ch <= CH_W'(N_CH - 1);
         ch      <= '0;
         sel     <= '0;
         widx    <= '0;
         rd_q    <= 1'b0;
         sreg    <= '0;
         cnt     <= '0;
         bcnt    <= '0;
         RD_ADDR <= '0;
         RD_EN   <= 1'b0;
         TX_DAT  <= '0;
         TX_CLK  <= '0;
         TX_OE_N <= '1;
         TX_END  <= '0;
         BUSY    <= 1'b0;
`ifdef NANEYE_CFG_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         pend <= (pend & ~((state == IDLE && grant) ? grant_oh : '0)) | START;
         rd_q <= RD_EN;
         TX_END <= '0;
         // Bank data lags RD_EN by one cycle; words stack up as {word0, word1, ..}.
         if (rd_q) sreg <= (sreg << DATA_W) | SR_W'(INPUT);
         case (state)
            IDLE: if (grant) begin
               state   <= LOAD;
               ch      <= grant_ch;
               sel     <= grant_oh;
               BUSY    <= 1'b1;
               RD_EN   <= 1'b1;
               RD_ADDR <= {grant_ch, WORD_W'(0)};
               widx    <= '0;
            end
            LOAD: if (RD_EN) begin
               if (widx == WORD_W'(NWORDS - 1)) RD_EN <= 1'b0;
               else begin
                  widx    <= widx + 1'b1;
                  RD_ADDR <= {ch, widx + 1'b1};
               end
            end else begin
               state   <= OE;
               TX_OE_N <= ~sel;
               cnt     <= '0;
            end
            OE: if (cnt == CNT_W'(2 * HALF - 1)) begin
               state  <= SHIFT;
               cnt    <= '0;
               bcnt   <= '0;
               TX_DAT <= sel & {N_CH{sreg[SR_W-1]}};
               sreg   <= sreg << 1;
`ifdef NANEYE_CFG_PARITY_EN
               par    <= ^sreg[SR_W-1 -: C_NO_CFG_BITS];
`endif
            end else cnt <= cnt + 1'b1;
            SHIFT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(HALF - 1)) TX_CLK <= sel;
               if (cnt == CNT_W'(2 * HALF - 1)) begin
                  cnt    <= '0;
                  TX_CLK <= '0;
                  if (bcnt == BC_W'(BITS - 1)) begin
                     state  <= HOLD;
                     TX_DAT <= '0;
                  end else begin
                     bcnt   <= bcnt + 1'b1;
                     TX_DAT <= sel & {N_CH{nxt}};
                     sreg   <= sreg << 1;
                  end
               end
            end
            HOLD: if (cnt == CNT_W'(2 * HALF - 1)) begin
               state   <= IDLE;
               TX_OE_N <= '1;
               TX_END  <= sel;
               last_ch <= ch;
               BUSY    <= 1'b0;
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
